multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// multicycle_ctrl: multicycle CPU control FSM with memory handshake timeout.
// Rev 1.0
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       branch_o,
  output logic       branch_type_o,
  output logic       jal_o,
  output logic       rt_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] state_o,
  output logic       done_o,
  output logic       illegal_o,
  output logic       bus_err_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] EXEC   = 4'd2;
  localparam logic [3:0] MEM_RD = 4'd3;
  localparam logic [3:0] MEM_WR = 4'd4;
  localparam logic [3:0] WB_ALU = 4'd5;
  localparam logic [3:0] WB_MEM = 4'd6;
  localparam logic [3:0] BRANCH = 4'd7;
  localparam logic [3:0] JUMP   = 4'd8;
  localparam logic [3:0] ERROR  = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b101100;
  localparam logic [5:0] OP_SW    = 6'b101101;
  localparam logic [5:0] OP_BEQ   = 6'b001010;
  localparam logic [5:0] OP_BNE   = 6'b001011;
  localparam logic [5:0] OP_BLT   = 6'b001110;
  localparam logic [5:0] OP_BNEZ  = 6'b001100;
  localparam logic [5:0] OP_BGEZ  = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  logic [3:0]    state;
  logic [3:0]    state_next;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;
  logic          mem_wait;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_wait   = 1'b0;
    case (state)
      FETCH:  if (mem_ready_i) state_next = DECODE; else mem_wait = 1'b1;
      DECODE: begin
        case (instr_op_i)
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW:             state_next = EXEC;
          OP_BEQ, OP_BNE, OP_BLT, OP_BNEZ, OP_BGEZ:    state_next = BRANCH;
          OP_J, OP_JAL:                                state_next = JUMP;
          default:                                     state_next = FETCH;
        endcase
      end
      EXEC: begin
        case (instr_op_i)
          OP_RTYPE, OP_ADDI: state_next = WB_ALU;
          OP_LW:             state_next = MEM_RD;
          OP_SW:             state_next = MEM_WR;
          default:           state_next = FETCH;
        endcase
      end
      MEM_RD: if (mem_ready_i) state_next = WB_MEM; else mem_wait = 1'b1;
      MEM_WR: if (mem_ready_i) state_next = FETCH;  else mem_wait = 1'b1;
      WB_ALU, WB_MEM, BRANCH, JUMP: state_next = FETCH;
      ERROR:   state_next = ERROR;
      default: state_next = FETCH;
    endcase
    // The last permitted wait cycle without a ready escalates to ERROR.
    if (mem_wait && wait_cnt == WAIT_LAST) state_next = ERROR;

    if (state_next != state) wait_cnt_next = '0;
    else if (mem_wait)       wait_cnt_next = wait_cnt + 1'b1;
    else                     wait_cnt_next = wait_cnt;
  end

  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    iord_o        = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    branch_o      = 1'b0;
    branch_type_o = 1'b0;
    jal_o         = 1'b0;
    rt_o          = 1'b0;
    reg_write_o   = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    alu_op_o      = 3'b000;
    pc_src_o      = 2'b00;
    done_o        = 1'b0;
    illegal_o     = 1'b0;
    bus_err_o     = 1'b0;
    case (state)
      FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        case (instr_op_i)
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT,
          OP_BNEZ, OP_BGEZ, OP_J, OP_JAL: illegal_o = 1'b0;
          default:                        illegal_o = 1'b1;
        endcase
      end
      EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = (instr_op_i == OP_RTYPE) ? 2'b00 : 2'b10;
        if (instr_op_i == OP_RTYPE)     alu_op_o = 3'b010;
        else if (instr_op_i == OP_ADDI) alu_op_o = 3'b011;
      end
      MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      MEM_WR: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = 1'b1;
        done_o    = mem_ready_i;
      end
      WB_ALU: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (instr_op_i == OP_RTYPE);
        done_o      = 1'b1;
      end
      WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        done_o       = 1'b1;
      end
      BRANCH: begin
        branch_o    = 1'b1;
        alu_src_a_o = 1'b1;
        pc_src_o    = 2'b01;
        done_o      = 1'b1;
        case (instr_op_i)
          OP_BEQ:  alu_op_o = 3'b001;
          OP_BNE:  begin alu_op_o = 3'b110; branch_type_o = 1'b1; end
          OP_BNEZ: begin alu_op_o = 3'b110; branch_type_o = 1'b1; rt_o = 1'b1; end
          OP_BLT:  begin alu_op_o = 3'b100; branch_type_o = 1'b1; end
          OP_BGEZ: begin alu_op_o = 3'b101; rt_o = 1'b1; end
          default: alu_op_o = 3'b000;
        endcase
      end
      JUMP: begin
        pc_write_o  = 1'b1;
        pc_src_o    = 2'b10;
        jal_o       = (instr_op_i == OP_JAL);
        reg_write_o = (instr_op_i == OP_JAL);
        done_o      = 1'b1;
      end
      ERROR:   bus_err_o = 1'b1;
      default: bus_err_o = 1'b0;
    endcase
  end

  assign state_o = state;

endmodule
`default_nettype wire
